pu_or1k_pfpu32_addsub_rnd: RTL and testbench

Back end of the pfpu32 add/sub path. It consumes the add/sub front-end output bundle: sign, left-shift amount, candidate exponents, 28-bit {carry,fract24,g,r,s} fraction and special-case flags. It then performs final normalization, IEEE-754 rounding (four modes), overflow/underflow handling and packing into a 32-bit single-precision result with exception flags. It is a two-stage pipeline under the shared adv_i/flush_i pipe control, feeding the FPU result mux.

---
 rtl/pu_or1k_pfpu32_addsub_rnd.sv | 229 ++++++++++++++++++++++
 tb/tb_pu_or1k_pfpu32_addsub_rnd.sv | 282 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/pu_or1k_pfpu32_addsub_rnd.sv
// pfpu32 add/sub back end: normalise, round (4 modes), pack to IEEE single.
// Two stages on adv_i. In: front-end bundle. Out: rnd_result_o + flags.
module pu_or1k_pfpu32_addsub_rnd (
  input  logic        clk,
  input  logic        rst,
  input  logic        flush_i,
  input  logic        adv_i,
  input  logic [1:0]  rmode_i,
  input  logic        add_rdy_i,
  input  logic        add_sign_i,
  input  logic        add_sub_0_i,
  input  logic [4:0]  add_shl_i,
  input  logic [9:0]  add_exp10shl_i,
  input  logic [9:0]  add_exp10sh0_i,
  input  logic [27:0] add_fract28_i,
  input  logic        add_inv_i,
  input  logic        add_inf_i,
  input  logic        add_snan_i,
  input  logic        add_qnan_i,
  input  logic        add_anan_sign_i,
  output logic        rnd_rdy_o,
  output logic [31:0] rnd_result_o,
  output logic        rnd_ine_o,
  output logic        rnd_ovf_o,
  output logic        rnd_unf_o,
  output logic        rnd_inv_o,
  output logic        rnd_inf_o,
  output logic        rnd_zer_o,
  output logic        rnd_snan_o,
  output logic        rnd_qnan_o
);

  localparam logic [1:0] RNE = 2'd0;
  localparam logic [1:0] RTZ = 2'd1;
  localparam logic [1:0] RUP = 2'd2;
  localparam logic [1:0] RDN = 2'd3;

  logic [26:0] f_shl;
  logic [23:0] a_fract;
  logic        a_g;
  logic        a_st;
  logic [9:0]  a_exp;

  assign f_shl = add_fract28_i[26:0] << add_shl_i;

  always_comb begin
    a_fract = add_fract28_i[26:3];
    a_g     = add_fract28_i[2];
    a_st    = |add_fract28_i[1:0];
    a_exp   = add_exp10sh0_i;
    unique case (1'b1)
      add_fract28_i[27]: begin
        a_fract = add_fract28_i[27:4];
        a_g     = add_fract28_i[3];
        a_st    = |add_fract28_i[2:0];
        a_exp   = add_exp10sh0_i + 10'd1;
      end
      (!add_fract28_i[27] && add_shl_i != 5'd0): begin
        a_fract = f_shl[26:3];
        a_g     = f_shl[2];
        a_st    = |f_shl[1:0];
        a_exp   = add_exp10shl_i;
      end
      default: ;
    endcase
  end

  logic        s1_rdy;
  logic        s1_sign;
  logic        s1_sub0;
  logic [1:0]  s1_rm;
  logic [23:0] s1_fract;
  logic        s1_g;
  logic        s1_st;
  logic [9:0]  s1_exp;
  logic        s1_inv;
  logic        s1_inf;
  logic        s1_snan;
  logic        s1_qnan;
  logic        s1_asign;

  always_ff @(posedge clk) begin
    if (!rst) begin
      s1_rdy   <= 1'b0;
      s1_sign  <= 1'b0;
      s1_sub0  <= 1'b0;
      s1_rm    <= 2'd0;
      s1_fract <= 24'd0;
      s1_g     <= 1'b0;
      s1_st    <= 1'b0;
      s1_exp   <= 10'd0;
      s1_inv   <= 1'b0;
      s1_inf   <= 1'b0;
      s1_snan  <= 1'b0;
      s1_qnan  <= 1'b0;
      s1_asign <= 1'b0;
    end else if (flush_i) begin
      s1_rdy <= 1'b0;
    end else if (adv_i) begin
      s1_rdy   <= add_rdy_i;
      s1_sign  <= add_sign_i;
      s1_sub0  <= add_sub_0_i;
      s1_rm    <= rmode_i;
      s1_fract <= a_fract;
      s1_g     <= a_g;
      s1_st    <= a_st;
      s1_exp   <= a_exp;
      s1_inv   <= add_inv_i;
      s1_inf   <= add_inf_i;
      s1_snan  <= add_snan_i;
      s1_qnan  <= add_qnan_i;
      s1_asign <= add_anan_sign_i;
    end
  end

  logic        inx;
  logic        up;
  logic [24:0] f25;
  logic [23:0] fr;
  logic [10:0] ex;
  logic        ovf;
  logic        to_inf;
  logic [30:0] mag;
  logic        zero;
  logic        nan;

  always_comb begin
    inx = s1_g | s1_st;
    up  = 1'b0;
    unique case (s1_rm)
      RNE: up = s1_g & (s1_st | s1_fract[0]);
      RTZ: up = 1'b0;
      RUP: up = ~s1_sign & inx;
      RDN: up = s1_sign & inx;
    endcase
  end

  // Carry out of the increment renormalises by one; a denormal that
  // rounds into the hidden bit picks up its exponent field from s1_exp.
  assign f25    = {1'b0, s1_fract} + {24'd0, up};
  assign fr     = f25[24] ? f25[24:1] : f25[23:0];
  assign ex     = {1'b0, s1_exp} + {10'd0, f25[24]};
  assign ovf    = ex >= 11'd255;
  assign to_inf = (s1_rm == RNE)
                | ((s1_rm == RUP) & ~s1_sign)
                | ((s1_rm == RDN) & s1_sign);
  assign mag    = {fr[23] ? ex[7:0] : 8'd0, fr[22:0]};
  assign zero   = (mag == 31'd0);
  assign nan    = s1_snan | s1_qnan | s1_inv;

  logic [31:0] n_res;
  logic        n_ine;
  logic        n_ovf;
  logic        n_unf;
  logic        n_inv;
  logic        n_inf;
  logic        n_zer;
  logic        n_snan;
  logic        n_qnan;

  always_comb begin
    n_res  = {(zero & s1_sub0) ? (s1_rm == RDN) : s1_sign, mag};
    n_ine  = inx;
    n_ovf  = 1'b0;
    n_unf  = ~fr[23] & inx;
    n_inv  = 1'b0;
    n_inf  = 1'b0;
    n_zer  = zero;
    n_snan = 1'b0;
    n_qnan = 1'b0;
    unique case (1'b1)
      nan: begin
        n_res  = {s1_asign, 8'hFF, 1'b1, 22'd0};
        n_ine  = 1'b0;
        n_unf  = 1'b0;
        n_zer  = 1'b0;
        n_inv  = s1_inv | s1_snan;
        n_qnan = 1'b1;
        n_snan = s1_snan;
      end
      (~nan & s1_inf): begin
        n_res = {s1_sign, 8'hFF, 23'd0};
        n_ine = 1'b0;
        n_unf = 1'b0;
        n_zer = 1'b0;
        n_inf = 1'b1;
      end
      (~nan & ~s1_inf & ovf): begin
        n_res = to_inf ? {s1_sign, 8'hFF, 23'd0}
                       : {s1_sign, 8'hFE, 23'h7FFFFF};
        n_ine = 1'b1;
        n_ovf = 1'b1;
        n_unf = 1'b0;
        n_zer = 1'b0;
        n_inf = to_inf;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      rnd_rdy_o    <= 1'b0;
      rnd_result_o <= 32'd0;
      rnd_ine_o    <= 1'b0;
      rnd_ovf_o    <= 1'b0;
      rnd_unf_o    <= 1'b0;
      rnd_inv_o    <= 1'b0;
      rnd_inf_o    <= 1'b0;
      rnd_zer_o    <= 1'b0;
      rnd_snan_o   <= 1'b0;
      rnd_qnan_o   <= 1'b0;
    end else if (flush_i) begin
      rnd_rdy_o <= 1'b0;
    end else if (adv_i) begin
      rnd_rdy_o    <= s1_rdy;
      rnd_result_o <= n_res;
      rnd_ine_o    <= n_ine;
      rnd_ovf_o    <= n_ovf;
      rnd_unf_o    <= n_unf;
      rnd_inv_o    <= n_inv;
      rnd_inf_o    <= n_inf;
      rnd_zer_o    <= n_zer;
      rnd_snan_o   <= n_snan;
      rnd_qnan_o   <= n_qnan;
    end
  end

endmodule

// File: tb/tb_pu_or1k_pfpu32_addsub_rnd.sv
// Bench for pu_or1k_pfpu32_addsub_rnd: directed cases, pipe control,
// and random bundles checked against an arithmetic rounding model.
module tb_pu_or1k_pfpu32_addsub_rnd;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        flush_i = 1'b0;
  logic        adv_i = 1'b0;
  logic [1:0]  rmode_i = 2'd0;
  logic        add_rdy_i = 1'b0;
  logic        add_sign_i = 1'b0;
  logic        add_sub_0_i = 1'b0;
  logic [4:0]  add_shl_i = 5'd0;
  logic [9:0]  add_exp10shl_i = 10'd0;
  logic [9:0]  add_exp10sh0_i = 10'd0;
  logic [27:0] add_fract28_i = 28'd0;
  logic        add_inv_i = 1'b0;
  logic        add_inf_i = 1'b0;
  logic        add_snan_i = 1'b0;
  logic        add_qnan_i = 1'b0;
  logic        add_anan_sign_i = 1'b0;
  logic        rnd_rdy_o;
  logic [31:0] rnd_result_o;
  logic        rnd_ine_o, rnd_ovf_o, rnd_unf_o, rnd_inv_o;
  logic        rnd_inf_o, rnd_zer_o, rnd_snan_o, rnd_qnan_o;
  logic [7:0]  fl;

  int n_vec = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  assign fl = {rnd_ine_o, rnd_ovf_o, rnd_unf_o, rnd_inv_o,
               rnd_inf_o, rnd_zer_o, rnd_snan_o, rnd_qnan_o};

  pu_or1k_pfpu32_addsub_rnd dut (
    .clk(clk), .rst(rst), .flush_i(flush_i), .adv_i(adv_i),
    .rmode_i(rmode_i), .add_rdy_i(add_rdy_i),
    .add_sign_i(add_sign_i), .add_sub_0_i(add_sub_0_i),
    .add_shl_i(add_shl_i), .add_exp10shl_i(add_exp10shl_i),
    .add_exp10sh0_i(add_exp10sh0_i), .add_fract28_i(add_fract28_i),
    .add_inv_i(add_inv_i), .add_inf_i(add_inf_i),
    .add_snan_i(add_snan_i), .add_qnan_i(add_qnan_i),
    .add_anan_sign_i(add_anan_sign_i),
    .rnd_rdy_o(rnd_rdy_o), .rnd_result_o(rnd_result_o),
    .rnd_ine_o(rnd_ine_o), .rnd_ovf_o(rnd_ovf_o),
    .rnd_unf_o(rnd_unf_o), .rnd_inv_o(rnd_inv_o),
    .rnd_inf_o(rnd_inf_o), .rnd_zer_o(rnd_zer_o),
    .rnd_snan_o(rnd_snan_o), .rnd_qnan_o(rnd_qnan_o)
  );

  typedef struct {
    logic [1:0]  rm;
    logic        sign;
    logic        sub0;
    logic [4:0]  shl;
    logic [9:0]  eshl;
    logic [9:0]  esh0;
    logic [27:0] f;
    logic        inv;
    logic        inf;
    logic        snan;
    logic        qnan;
    logic        asign;
  } bun_t;

  function automatic bun_t mk(input logic [27:0] f, input logic [9:0] esh0,
                              input logic [1:0] rm, input logic sign);
    bun_t b;
    b.rm = rm; b.sign = sign; b.sub0 = 1'b0; b.shl = 5'd0;
    b.eshl = 10'd0; b.esh0 = esh0; b.f = f;
    b.inv = 1'b0; b.inf = 1'b0; b.snan = 1'b0; b.qnan = 1'b0;
    b.asign = 1'b0;
    return b;
  endfunction

  // Reference: treat the bundle as an integer significand, divide off the
  // discarded bits, round by comparing the remainder with one half.
  function automatic logic [39:0] model(input bun_t b);
    longint m, q, rem, half;
    int e, k;
    logic up, inx, toinf, s;
    logic [7:0] ef;
    logic [30:0] mag;
    if (b.snan | b.qnan | b.inv)
      return {b.asign, 8'hFF, 1'b1, 22'd0,
              3'b000, b.inv | b.snan, 2'b00, b.snan, 1'b1};
    if (b.inf)
      return {b.sign, 8'hFF, 23'd0, 8'h08};
    if (b.f[27]) begin
      k = 4; m = longint'(b.f); e = int'(b.esh0) + 1;
    end else begin
      k = 3; m = longint'(b.f) << b.shl;
      e = (b.shl != 5'd0) ? int'(b.eshl) : int'(b.esh0);
    end
    half = longint'(1) << (k - 1);
    q = m >> k;
    rem = m - (q << k);
    inx = (rem != 0);
    case (b.rm)
      2'd0: up = (rem > half) || (rem == half && q[0]);
      2'd1: up = 1'b0;
      2'd2: up = !b.sign && inx;
      default: up = b.sign && inx;
    endcase
    q = q + longint'(up);
    if (q >= (longint'(1) << 24)) begin
      q = q >> 1; e++;
    end
    if (e >= 255) begin
      toinf = (b.rm == 2'd0) || (b.rm == 2'd2 && !b.sign)
           || (b.rm == 2'd3 && b.sign);
      if (toinf) return {b.sign, 8'hFF, 23'd0, 8'hC8};
      return {b.sign, 8'hFE, 23'h7FFFFF, 8'hC0};
    end
    ef = (q >= (longint'(1) << 23)) ? e[7:0] : 8'd0;
    mag = {ef, q[22:0]};
    s = (mag == 31'd0 && b.sub0) ? (b.rm == 2'd3) : b.sign;
    return {s, mag, inx, 1'b0, (q < (longint'(1) << 23)) && inx,
            2'b00, mag == 31'd0, 2'b00};
  endfunction

  function automatic bun_t rnd_bun();
    bun_t b;
    logic [31:0] t;
    int sel, p;
    t = $urandom;
    b = mk(28'd0, 10'd0, t[1:0], t[2]);
    b.eshl = 10'($urandom_range(1, 254));
    b.esh0 = 10'($urandom_range(1, 254));
    if (t[3]) b.esh0 = 10'($urandom_range(248, 254));
    sel = $urandom_range(0, 11);
    t = $urandom;
    case (sel)
      0, 1, 2: b.f = {1'b1, t[26:0]};
      3, 4, 5: begin
        b.shl = 5'($urandom_range(1, 20));
        p = 26 - int'(b.shl);
        b.f = 28'((t & ((32'd1 << p) - 32'd1)) | (32'd1 << p));
      end
      6, 7: b.f = {2'b01, t[25:0]};
      8: begin b.esh0 = 10'd1; b.f = {4'd0, t[23:0]}; end
      9: begin b.f = 28'd0; b.sub0 = t[4]; end
      10: begin
        b.f = t[27:0]; b.inf = 1'b1;
        b.qnan = t[29]; b.inv = t[30]; b.asign = t[31];
      end
      default: begin
        b.f = t[27:0]; b.snan = t[29]; b.qnan = ~t[29];
        b.inv = t[30]; b.asign = t[31];
      end
    endcase
    return b;
  endfunction

  task automatic drive(input bun_t b);
    rmode_i = b.rm; add_sign_i = b.sign; add_sub_0_i = b.sub0;
    add_shl_i = b.shl; add_exp10shl_i = b.eshl;
    add_exp10sh0_i = b.esh0; add_fract28_i = b.f;
    add_inv_i = b.inv; add_inf_i = b.inf; add_snan_i = b.snan;
    add_qnan_i = b.qnan; add_anan_sign_i = b.asign;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] expv);
    n_vec++;
    assert (obs === expv) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, expv);
    end
  endtask

  task automatic chk_out(input string tag, input logic [39:0] expv);
    chk({tag, ".rdy"}, {31'd0, rnd_rdy_o}, 32'd1);
    chk({tag, ".res"}, rnd_result_o, expv[39:8]);
    chk({tag, ".flg"}, {24'd0, fl}, {24'd0, expv[7:0]});
  endtask

  task automatic run(input bun_t b, input string tag,
                     input logic [39:0] expv);
    drive(b); add_rdy_i = 1'b1; adv_i = 1'b1;
    @(posedge clk); #1;
    add_rdy_i = 1'b0;
    @(posedge clk); #1;
    chk_out(tag, expv);
  endtask

  bun_t b, a2, b2;

  initial begin
    rst = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst.rdy", {31'd0, rnd_rdy_o}, 32'd0);
    chk("rst.res", rnd_result_o, 32'd0);
    chk("rst.flg", {24'd0, fl}, 32'd0);
    rst = 1'b1;

    run(mk(28'h8000000, 10'd127, 2'd0, 1'b0), "one_plus_one",
        {32'h40000000, 8'h00});
    run(mk(28'h400000C, 10'd127, 2'd0, 1'b0), "tie_rne",
        {32'h3F800002, 8'h80});
    run(mk(28'h400000C, 10'd127, 2'd1, 1'b0), "tie_rtz",
        {32'h3F800001, 8'h80});
    run(mk(28'h400000C, 10'd127, 2'd2, 1'b1), "tie_rup_neg",
        {32'hBF800001, 8'h80});
    run(mk(28'h8000000, 10'd254, 2'd0, 1'b0), "ovf_rne",
        {32'h7F800000, 8'hC8});
    run(mk(28'h8000000, 10'd254, 2'd1, 1'b0), "ovf_rtz",
        {32'h7F7FFFFF, 8'hC0});
    run(mk(28'h000001C, 10'd1, 2'd0, 1'b0), "denorm_rne",
        {32'h00000004, 8'hA0});
    run(mk(28'h3FFFFFC, 10'd1, 2'd0, 1'b0), "denorm_to_norm",
        {32'h00800000, 8'h80});

    b = mk(28'd0, 10'd0, 2'd0, 1'b1); b.sub0 = 1'b1;
    run(b, "zero_rne", {32'h00000000, 8'h04});
    b = mk(28'd0, 10'd0, 2'd3, 1'b0); b.sub0 = 1'b1;
    run(b, "zero_rdn", {32'h80000000, 8'h04});
    b = mk(28'h123, 10'd5, 2'd0, 1'b0); b.snan = 1'b1;
    run(b, "snan", {32'h7FC00000, 8'h13});
    b = mk(28'h8000000, 10'd200, 2'd0, 1'b1); b.inf = 1'b1;
    run(b, "inf_neg", {32'hFF800000, 8'h08});
    b = mk(28'h8000000, 10'd200, 2'd0, 1'b0);
    b.inf = 1'b1; b.inv = 1'b1;
    run(b, "inv_over_inf", {32'h7FC00000, 8'h11});

    // back-to-back then a 3-cycle stall with the first result on show
    a2 = mk(28'h8000000, 10'd127, 2'd0, 1'b0);
    b2 = mk(28'h400000C, 10'd127, 2'd1, 1'b0);
    drive(a2); add_rdy_i = 1'b1; adv_i = 1'b1;
    @(posedge clk); #1;
    drive(b2);
    @(posedge clk); #1;
    chk_out("b2b_first", {32'h40000000, 8'h00});
    add_rdy_i = 1'b0; adv_i = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      chk_out($sformatf("stall%0d", i), {32'h40000000, 8'h00});
    end
    adv_i = 1'b1;
    @(posedge clk); #1;
    chk_out("b2b_second", {32'h3F800001, 8'h80});
    @(posedge clk); #1;
    chk("drain.rdy", {31'd0, rnd_rdy_o}, 32'd0);

    // flush one cycle after the bundle enters
    drive(a2); add_rdy_i = 1'b1;
    @(posedge clk); #1;
    add_rdy_i = 1'b0; flush_i = 1'b1;
    @(posedge clk); #1;
    flush_i = 1'b0;
    chk("flush0.rdy", {31'd0, rnd_rdy_o}, 32'd0);
    @(posedge clk); #1;
    chk("flush1.rdy", {31'd0, rnd_rdy_o}, 32'd0);

    // reset with one result valid and another in stage 1
    drive(a2); add_rdy_i = 1'b1;
    @(posedge clk); #1;
    drive(b2);
    @(posedge clk); #1;
    add_rdy_i = 1'b0;
    chk_out("prerst", {32'h40000000, 8'h00});
    rst = 1'b0;
    @(posedge clk); #1;
    rst = 1'b1;
    chk("midrst.rdy", {31'd0, rnd_rdy_o}, 32'd0);
    chk("midrst.res", rnd_result_o, 32'd0);
    chk("midrst.flg", {24'd0, fl}, 32'd0);
    @(posedge clk); #1;
    chk("postrst.rdy", {31'd0, rnd_rdy_o}, 32'd0);

    for (int i = 0; i < 60; i++) begin
      b = rnd_bun();
      run(b, $sformatf("rnd%0d", i), model(b));
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
